// File: rtl/risc16_pkg.sv
// Shared RISC16 definitions: opcodes, control-FSM state encoding and ALU select codes.
// Used by the control unit and by the datapath ALU.
package risc16_pkg;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_LATCH, S_DECODE,
    S_LD1, S_LD2, S_ST1, S_ST2, S_LI,
    S_AL1, S_AL2, S_JZ1, S_JZ2, S_HALT
  } state_t;

  localparam logic [3:0] OP_LD   = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LI   = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_JZ   = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_SLA  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SLA = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_IMM = 2'b10;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_XOR) || (op == OP_NOT) || (op == OP_SLA) || (op == OP_SRA);
  endfunction

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    logic [2:0] s;
    case (op)
      OP_SUB:  s = ALU_SUB;
      OP_AND:  s = ALU_AND;
      OP_OR:   s = ALU_OR;
      OP_XOR:  s = ALU_XOR;
      OP_NOT:  s = ALU_NOT;
      OP_SLA:  s = ALU_SLA;
      OP_SRA:  s = ALU_SRA;
      default: s = ALU_ADD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/risc16_control_unit_if.sv
// Instruction-memory bus between the control unit (master) and the instruction memory.
// Read data is expected one cycle after the read strobe.
interface risc16_control_unit_if #(parameter int W = 16);
  logic [W-1:0] imem_addr;
  logic         imem_rd;
  logic [W-1:0] imem_data;

  modport master (output imem_addr, output imem_rd, input imem_data);
  modport slave  (input imem_addr, input imem_rd, output imem_data);
endinterface

// File: rtl/risc16_pc.sv
// Program counter: post-fetch increment, relative branch load, asynchronous clear.
// Branch target is relative to the branch's own address (PC was already incremented).
module risc16_pc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         br,
  input  logic [7:0]   offset,
  output logic [W-1:0] pc
);

  logic [W-1:0] sext;
  assign sext = {{(W-8){offset[7]}}, offset};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + W'(1);
    end else if (br) begin
      pc <= pc - W'(1) + sext;
    end
  end

endmodule

// File: rtl/risc16_control_unit.sv
// RISC16 multi-cycle control FSM: fetch/latch/decode then per-opcode execute states.
// Outputs are Moore decodes of state and IR, so reset forces them all low at once.
module risc16_control_unit
  import risc16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  risc16_control_unit_if.master  imem,
  input  logic                   RF_Rp_zero,
  output logic [7:0]             D_addr,
  output logic                   D_rd,
  output logic                   D_wr,
  output logic [7:0]             RF_W_data,
  output logic                   RF_s1,
  output logic                   RF_s0,
  output logic [3:0]             RF_W_addr,
  output logic                   W_wr,
  output logic [3:0]             RF_Rp_addr,
  output logic                   Rp_rd,
  output logic [3:0]             RF_Rq_addr,
  output logic                   Rq_rd,
  output logic [2:0]             alu_s,
  output logic                   halted
);

  state_t       state, nxt;
  logic [W-1:0] ir;
  logic [W-1:0] pc;
  logic [3:0]   op, ra, rb, rc;
  logic [1:0]   wsel;

  assign op = ir[15:12];
  assign ra = ir[11:8];
  assign rb = ir[7:4];
  assign rc = ir[3:0];
  assign RF_s1 = wsel[1];
  assign RF_s0 = wsel[0];

  risc16_pc #(.W(W)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (state == S_LATCH),
    .br     ((state == S_JZ2) && RF_Rp_zero),
    .offset (ir[7:0]),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (state == S_LATCH) ir <= imem.imem_data;
    end
  end

  always_comb begin
    nxt            = state;
    imem.imem_addr = '0;
    imem.imem_rd   = 1'b0;
    D_addr         = '0;
    D_rd           = 1'b0;
    D_wr           = 1'b0;
    RF_W_data      = '0;
    wsel           = WSEL_ALU;
    RF_W_addr      = '0;
    W_wr           = 1'b0;
    RF_Rp_addr     = '0;
    Rp_rd          = 1'b0;
    RF_Rq_addr     = '0;
    Rq_rd          = 1'b0;
    alu_s          = '0;
    halted         = 1'b0;

    case (state)
      S_INIT:   nxt = S_FETCH;
      S_FETCH: begin
        imem.imem_addr = pc;
        imem.imem_rd   = 1'b1;
        nxt            = S_LATCH;
      end
      S_LATCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LD:   nxt = S_LD1;
          OP_ST:   nxt = S_ST1;
          OP_LI:   nxt = S_LI;
          OP_JZ:   nxt = S_JZ1;
          OP_HALT: nxt = S_HALT;
          // NOP idles one strobe-free cycle in INIT to keep its 4-cycle CPI.
          default: nxt = is_alu_op(op) ? S_AL1 : S_INIT;
        endcase
      end
      S_LD1: begin
        D_addr = ir[7:0];
        D_rd   = 1'b1;
        nxt    = S_LD2;
      end
      S_LD2: begin
        W_wr      = 1'b1;
        RF_W_addr = ra;
        wsel      = WSEL_MEM;
        nxt       = S_FETCH;
      end
      S_ST1: begin
        RF_Rp_addr = ra;
        Rp_rd      = 1'b1;
        nxt        = S_ST2;
      end
      S_ST2: begin
        D_addr = ir[7:0];
        D_wr   = 1'b1;
        nxt    = S_FETCH;
      end
      S_LI: begin
        W_wr      = 1'b1;
        RF_W_addr = ra;
        wsel      = WSEL_IMM;
        RF_W_data = ir[7:0];
        nxt       = S_FETCH;
      end
      S_AL1: begin
        RF_Rp_addr = rb;
        RF_Rq_addr = rc;
        Rp_rd      = 1'b1;
        Rq_rd      = 1'b1;
        nxt        = S_AL2;
      end
      S_AL2: begin
        W_wr      = 1'b1;
        RF_W_addr = ra;
        wsel      = WSEL_ALU;
        alu_s     = alu_sel(op);
        nxt       = S_FETCH;
      end
      S_JZ1: begin
        RF_Rp_addr = ra;
        Rp_rd      = 1'b1;
        nxt        = S_JZ2;
      end
      S_JZ2:    nxt = S_FETCH;
      S_HALT:   halted = 1'b1;
      default:  nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_risc16_control_unit.sv
// Scoreboard bench: expected strobe snapshots are queued by the stimulus and
// checked by a negedge monitor whenever the DUT raises any strobe.
module tb_risc16_control_unit;

  typedef struct packed {
    logic [15:0] ia;
    logic        ird;
    logic [7:0]  da;
    logic        drd;
    logic        dwr;
    logic [7:0]  wd;
    logic [1:0]  sel;
    logic [3:0]  wa;
    logic        wwr;
    logic [3:0]  pa;
    logic        prd;
    logic [3:0]  qa;
    logic        qrd;
    logic [2:0]  alu;
  } snap_t;

  typedef struct {
    snap_t s;
    int    gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rp_zero;
  logic zero_cfg;
  logic [7:0] D_addr, RF_W_data;
  logic D_rd, D_wr, RF_s1, RF_s0, W_wr, Rp_rd, Rq_rd, halted;
  logic [3:0] RF_W_addr, RF_Rp_addr, RF_Rq_addr;
  logic [2:0] alu_s;

  logic [15:0] mem [0:15];
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fetch = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  risc16_control_unit_if #(.W(16)) imem_bus ();

  risc16_control_unit #(.W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem_bus),
    .RF_Rp_zero (rp_zero),
    .D_addr     (D_addr),
    .D_rd       (D_rd),
    .D_wr       (D_wr),
    .RF_W_data  (RF_W_data),
    .RF_s1      (RF_s1),
    .RF_s0      (RF_s0),
    .RF_W_addr  (RF_W_addr),
    .W_wr       (W_wr),
    .RF_Rp_addr (RF_Rp_addr),
    .Rp_rd      (Rp_rd),
    .RF_Rq_addr (RF_Rq_addr),
    .Rq_rd      (Rq_rd),
    .alu_s      (alu_s),
    .halted     (halted)
  );

  // Instruction memory and registered Rp==0 flag.
  always @(posedge clk) begin
    cyc++;
    if (imem_bus.imem_rd) imem_bus.imem_data <= mem[imem_bus.imem_addr[3:0]];
    if (Rp_rd) rp_zero <= zero_cfg;
  end

  function automatic snap_t cur();
    snap_t s;
    s.ia = imem_bus.imem_addr; s.ird = imem_bus.imem_rd;
    s.da = D_addr; s.drd = D_rd; s.dwr = D_wr;
    s.wd = RF_W_data; s.sel = {RF_s1, RF_s0}; s.wa = RF_W_addr; s.wwr = W_wr;
    s.pa = RF_Rp_addr; s.prd = Rp_rd; s.qa = RF_Rq_addr; s.qrd = Rq_rd;
    s.alu = alu_s;
    return s;
  endfunction

  function automatic snap_t f_fetch(input logic [15:0] a);
    snap_t s = '0;
    s.ia = a; s.ird = 1'b1;
    return s;
  endfunction

  function automatic snap_t f_wr(input logic [3:0] wa, input logic [1:0] sel,
                                 input logic [7:0] wd, input logic [2:0] alu);
    snap_t s = '0;
    s.wwr = 1'b1; s.wa = wa; s.sel = sel; s.wd = wd; s.alu = alu;
    return s;
  endfunction

  function automatic snap_t f_rd(input logic [3:0] pa, input logic [3:0] qa, input logic qrd);
    snap_t s = '0;
    s.pa = pa; s.prd = 1'b1; s.qa = qa; s.qrd = qrd;
    return s;
  endfunction

  function automatic snap_t f_mem(input logic [7:0] da, input logic rd, input logic wr);
    snap_t s = '0;
    s.da = da; s.drd = rd; s.dwr = wr;
    return s;
  endfunction

  task automatic push(input snap_t s, input int gap);
    exp_t e;
    e.s = s; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every strobe cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      snap_t s;
      exp_t  e;
      s = cur();
      if (s.ird | s.drd | s.dwr | s.wwr | s.prd | s.qrd) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe got=%h t=%0t", s, $time);
        end else begin
          e = q.pop_front();
          if (s !== e.s) begin
            failures++;
            $display("FAIL strobe_snapshot got=%h exp=%h t=%0t", s, e.s, $time);
          end
          if (s.ird && e.gap != 0) begin
            checks++;
            if (cyc - last_fetch != e.gap) begin
              failures++;
              $display("FAIL cpi addr=%0h got=%0d exp=%0d", s.ia, cyc - last_fetch, e.gap);
            end
          end
        end
        if (s.ird) last_fetch = cyc;
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #3;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0 pending", q.size());
      q.delete();
    end
  endtask

  // LI, ADD, LD, ST, NOP, then JZ1 at address 5.
  task automatic push_prefix();
    push(f_fetch(16'd0), 0);
    push(f_wr(4'd1, 2'b10, 8'h05, 3'b000), 0);
    push(f_fetch(16'd1), 4);
    push(f_rd(4'd1, 4'd2, 1'b1), 0);
    push(f_wr(4'd3, 2'b00, 8'h00, 3'b000), 0);
    push(f_fetch(16'd2), 5);
    push(f_mem(8'h10, 1'b1, 1'b0), 0);
    push(f_wr(4'd4, 2'b01, 8'h00, 3'b000), 0);
    push(f_fetch(16'd3), 5);
    push(f_rd(4'd4, 4'd0, 1'b0), 0);
    push(f_mem(8'h20, 1'b0, 1'b1), 0);
    push(f_fetch(16'd4), 5);
    push(f_fetch(16'd5), 4);
    push(f_rd(4'd1, 4'd0, 1'b0), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'hF000;
    mem[0] = 16'h3105; mem[1] = 16'h2312; mem[2] = 16'h0410; mem[3] = 16'h1420;
    mem[4] = 16'hC000; mem[5] = 16'h51FE; mem[6] = 16'h4567; mem[7] = 16'hB123;
    mem[8] = 16'hF000;
    rst_n = 1'b0;
    zero_cfg = 1'b1;
    rp_zero = 1'b0;
    imem_bus.imem_data = 16'h0;
    #12;
    chk("reset_outputs", 64'(cur()), 64'h0);
    chk("reset_halted", 64'(halted), 64'h0);
    mon_en = 1'b1;

    // Branch taken: 0x51FE at PC=5 returns to 3.
    push_prefix();
    push(f_fetch(16'd3), 5);
    release_reset();
    @(posedge clk); #2;
    chk("first_fetch_rd", 64'(imem_bus.imem_rd), 64'h1);
    chk("first_fetch_addr", 64'(imem_bus.imem_addr), 64'h0);
    drain(200);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 64'(cur()), 64'h0);

    // Branch not taken, then SUB, SRA and HALT.
    zero_cfg = 1'b0;
    push_prefix();
    push(f_fetch(16'd6), 5);
    push(f_rd(4'd6, 4'd7, 1'b1), 0);
    push(f_wr(4'd5, 2'b00, 8'h00, 3'b001), 0);
    push(f_fetch(16'd7), 5);
    push(f_rd(4'd2, 4'd3, 1'b1), 0);
    push(f_wr(4'd1, 2'b00, 8'h00, 3'b111), 0);
    push(f_fetch(16'd8), 5);
    release_reset();
    drain(200);
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      #2;
      chk("halted_high", 64'(halted), 64'h1);
      chk("halt_no_fetch", 64'(imem_bus.imem_rd), 64'h0);
      @(posedge clk);
    end

    // Reset out of HALT, then reset again while AL2 is writing.
    #3;
    rst_n = 1'b0;
    #1;
    chk("halt_cleared", 64'(halted), 64'h0);
    push(f_fetch(16'd0), 0);
    push(f_wr(4'd1, 2'b10, 8'h05, 3'b000), 0);
    push(f_fetch(16'd1), 4);
    push(f_rd(4'd1, 4'd2, 1'b1), 0);
    release_reset();
    drain(100);
    chk("al2_write_active", 64'(W_wr), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("al2_reset_wwr", 64'(W_wr), 64'h0);
    chk("al2_reset_outputs", 64'(cur()), 64'h0);
    chk("al2_reset_halted", 64'(halted), 64'h0);
    push(f_fetch(16'd0), 0);
    release_reset();
    drain(100);
    rst_n = 1'b0;
    mon_en = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc16_control_unit.md
RISC16_CONTROL_UNIT -- requirements
Module: risc16_control_unit

Interface
REQ-001 Parameter W, default 16: instruction/data word width; all other widths fixed as below.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_addr  output  16  instruction memory address (= PC).
REQ-005 imem_rd  output  1  instruction read strobe; imem_data valid one cycle later.
REQ-006 imem_data  input  16  instruction word: op[15:12], ra[11:8], rb[7:4], rc[3:0], imm/d/offset[7:0].
REQ-007 RF_Rp_zero  input  1  datapath flag: registered Rp read data == 0.
REQ-008 D_addr  output  8  data memory address.
REQ-009 D_rd  output  1  data memory read strobe.
REQ-010 D_wr  output  1  data memory write strobe (write data = datapath Rp read data).
REQ-011 RF_W_data  output  8  immediate for load-constant path (sign-extended by datapath).
REQ-012 RF_s1  output  1  write-mux select, high bit.
REQ-013 RF_s0  output  1  write-mux select, low bit ({s1,s0}: 00 ALU, 01 memory, 10 immediate).
REQ-014 RF_W_addr  output  4  register-file write address.
REQ-015 W_wr  output  1  register-file write enable.
REQ-016 RF_Rp_addr  output  4  register-file port P read address.
REQ-017 Rp_rd  output  1  port P read enable (data registered, one-cycle latency).
REQ-018 RF_Rq_addr  output  4  register-file port Q read address.
REQ-019 Rq_rd  output  1  port Q read enable.
REQ-020 alu_s  output  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SLA, 111 SRA.
REQ-021 halted  output  1  high while in HALT.

Function
REQ-022 States SHALL be INIT, FETCH, LATCH, DECODE, LD1, LD2, ST1, ST2, LI, AL1, AL2, JZ1, JZ2, HALT; registers: state, PC[15:0], IR[15:0].
REQ-023 INIT -> FETCH unconditionally; all strobes 0 in INIT.
REQ-024 FETCH: imem_rd=1, imem_addr=PC; -> LATCH.
REQ-025 LATCH: IR <= imem_data, PC <= PC+1 (mod 2^16, 0xFFFF wraps to 0); -> DECODE.
REQ-026 DECODE dispatch on IR[15:12]: 0000 LD1, 0001 ST1, 0011 LI, 0101 JZ1, 1111 HALT; 0010/0100/0110/0111/1000/1001/1010/1011 AL1; any other opcode SHALL be a NOP -> FETCH with no strobes.
REQ-027 LD1: D_addr=IR[7:0], D_rd=1; LD2: W_wr=1, RF_W_addr=ra, {s1,s0}=01; -> FETCH.
REQ-028 ST1: RF_Rp_addr=ra, Rp_rd=1; ST2: D_addr=IR[7:0], D_wr=1; -> FETCH.
REQ-029 LI: W_wr=1, RF_W_addr=ra, {s1,s0}=10, RF_W_data=IR[7:0]; -> FETCH.
REQ-030 AL1: RF_Rp_addr=rb, RF_Rq_addr=rc, Rp_rd=Rq_rd=1; AL2: W_wr=1, RF_W_addr=ra, {s1,s0}=00, alu_s by opcode order 0010,0100,0110,0111,1000,1001,1010,1011 -> 000..111; -> FETCH.
REQ-031 JZ1: RF_Rp_addr=ra, Rp_rd=1; JZ2: if RF_Rp_zero=1, PC <= PC-1+sext(IR[7:0]) mod 2^16, else PC unchanged; -> FETCH.
REQ-032 HALT: halted=1, no strobes, remains until reset.
REQ-033 Outputs not listed for a state SHALL be 0; addresses/selects outside their strobe states SHALL be 0.
REQ-034 CPI: LI and NOP 4 cycles; LD, ST, ALU, JZ 5 cycles.

Reset
REQ-035 rst_n low SHALL immediately (asynchronously) force state=INIT, PC=0, IR=0, all outputs 0, including mid-instruction (no partial write completes).
REQ-036 First FETCH SHALL occur in the second rising edge after rst_n deasserts (PC=0).

Structure
REQ-037 Opcode constants, state encoding and ALU select codes SHALL reside in a shared package risc16_pkg, also used by the ALU.
REQ-038 One sub-module risc16_pc (PC register: increment, branch-load, async clear) SHALL be instantiated.

Verification
REQ-039 Reset, imem[0]=0x3105 -> LI cycle: W_wr=1, RF_W_addr=1, {s1,s0}=10, RF_W_data=0x05; next imem_addr=1.
REQ-040 0x2312 -> AL1: Rp_addr=1, Rq_addr=2, both rd=1; AL2: W_wr=1, W_addr=3, alu_s=000, {s1,s0}=00.
REQ-041 0x0410 then 0x1420 -> D_rd with D_addr=0x10, then W_wr addr 4 sel 01; Rp_rd addr 4, then D_wr with D_addr=0x20.
REQ-042 0x51FE at PC=5: RF_Rp_zero=1 -> next imem_addr=3; RF_Rp_zero=0 -> next imem_addr=6.
REQ-043 0xC000 -> no strobes, next fetch PC+1; 0xF000 -> halted=1, imem_rd stays 0 for 20 cycles.
REQ-044 rst_n low during AL2 -> W_wr falls to 0 before next edge, halted=0, refetch from 0.
